conv_sat_narrow_stage: RTL
==========================

Name: conv_sat_narrow_stage

Overview:
- Pipelined narrowing stage that consumes a 32-bit value with a stated source signedness.
- Clamps the value to a selectable 8/16/32-bit signed or unsigned target range, then sign- or zero-extends the result back to 32 bits.
- Sits directly upstream of the combinational signed/unsigned conversion logic and feeds it already-legal, range-safe operands.
- Carries a valid/ready handshake and keeps a saturating count of clamp events.

Parameters:
- CNT_W, 16, width of the saturation-event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat this cycle
- in_data  input  32  source value
- in_signed  input  1  1: in_data is two's-complement; 0: unsigned
- in_width  input  2  target width: 00=8, 01=16, 10=32, 11=32
- in_out_signed  input  1  1: target range is signed; 0: unsigned
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  32  clamped result, extended to 32 bits
- out_sat  output  1  this beat was clamped
- sat_count  output  CNT_W  number of clamped beats accepted downstream
- sat_clr  input  1  synchronous clear of sat_count

Behaviour:
- Reset: the asynchronous rst clears all pipeline valids, out_data=0, out_sat=0 and sat_count=0. After reset, in_ready=1.
- Reset mid-operation discards all in-flight beats. No output beat is produced for them.
- Pipeline has two register stages, S1 and S2. Latency is 2 cycles from input acceptance to out_valid when not stalled.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, S1 and S2 hold their contents.
  - Bubbles in S1 are not collapsed.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- out_data, out_sat and out_valid are registered outputs and stay stable while out_valid && !out_ready.
- S1 registers:
  - the 33-bit signed source value: in_data extended by sign if in_signed, else by zero;
  - the width selection and the target signedness.
- S2 computes the clamp from the S1 contents and registers it:
  - signed target, width W: clamp to [-2^(W-1), 2^(W-1)-1];
  - unsigned target: clamp to [0, 2^W-1];
  - the W-bit result is sign-extended to 32 bits if the target is signed, else zero-extended;
  - out_sat=1 iff the source value lay outside the target range.
- W=32 cases follow the same rules. Example: unsigned 0x8000_0000 into a signed 32-bit target gives 0x7FFF_FFFF with sat=1.
- sat_count increments on each output transfer with out_sat=1 and sticks at 2^CNT_W-1.
  - sat_clr has priority over a simultaneous increment: the counter becomes 0.

Decomposition:
- conv_pkg holds:
  - typedef conv_width_e (W8=2'b00, W16=2'b01, W32=2'b10);
  - localparams for the per-width signed min/max and unsigned max, stored as 33-bit signed constants.
- Sub-module conv_sat_clamp (combinational):
  - inputs: 33-bit signed value, width, target signedness;
  - outputs: 32-bit extended result and the sat flag;
  - instantiated once in S2.

Test Plan:
1. Signed 0xFFFF_FF80 (-128) into an 8-bit signed target → out_data=0xFFFF_FF80, out_sat=0, out_valid exactly 2 cycles after acceptance.
2. Clamping of out-of-range sources:
   - Unsigned 0xFFFF_FF80 into 8-bit signed → 0x0000_007F, sat=1.
   - Signed 0xFFFF_FFFF into 16-bit unsigned → 0x0000_0000, sat=1.
   - Unsigned 0x0001_2345 into 16-bit unsigned → 0x0000_FFFF, sat=1.
3. 32-bit boundaries and the reserved width code:
   - Unsigned 0x8000_0000 into 32-bit signed → 0x7FFF_FFFF, sat=1.
   - Signed 0x8000_0000 into 32-bit unsigned → 0, sat=1.
   - in_width=11 behaves identically to 10.
4. Backpressure:
   - Stream 4 beats with out_ready=0 for 3 cycles → in_ready falls once S2 holds a beat and out_valid=1.
   - out_data stays stable throughout.
   - All 4 beats emerge in order with no loss or duplication.
5. Counter:
   - With CNT_W=4, 20 saturating beats → sat_count sticks at 15.
   - sat_clr in the same cycle as a saturating transfer → 0.
6. Reset mid-stream: assert rst with both stages valid → out_valid=0 immediately, sat_count=0, no stale beat after release.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and clamp bounds for the saturating narrowing stage.
// Bounds are 33-bit signed so they compare directly against any signed or unsigned 32-bit source.
package conv_pkg;

   typedef enum logic [1:0] {
      W8  = 2'b00,
      W16 = 2'b01,
      W32 = 2'b10
   } conv_width_e;

   localparam logic signed [32:0] S8_MIN  = -33'sd128;
   localparam logic signed [32:0] S8_MAX  = 33'sd127;
   localparam logic signed [32:0] S16_MIN = -33'sd32768;
   localparam logic signed [32:0] S16_MAX = 33'sd32767;
   localparam logic signed [32:0] S32_MIN = -33'sd2147483648;
   localparam logic signed [32:0] S32_MAX = 33'sd2147483647;
   localparam logic signed [32:0] U8_MAX  = 33'sd255;
   localparam logic signed [32:0] U16_MAX = 33'sd65535;
   localparam logic signed [32:0] U32_MAX = 33'sh0_FFFF_FFFF;

endpackage

// File: rtl/conv_sat_clamp.sv
// Combinational clamp of a 33-bit signed value into an 8/16/32-bit signed or unsigned range.
// Result is returned already sign- or zero-extended to 32 bits.
module conv_sat_clamp
   import conv_pkg::*;
(
   input  logic signed [32:0] i_val,
   input  logic [1:0]         i_width,
   input  logic               i_out_signed,
   output logic [31:0]        o_data,
   output logic               o_sat
);

   logic signed [32:0] w_min;
   logic signed [32:0] w_max;
   logic signed [32:0] w_clamped;

   always_comb begin
      w_min = '0;
      w_max = U32_MAX;
      case (i_width)
         W8: begin
            w_min = i_out_signed ? S8_MIN : '0;
            w_max = i_out_signed ? S8_MAX : U8_MAX;
         end
         W16: begin
            w_min = i_out_signed ? S16_MIN : '0;
            w_max = i_out_signed ? S16_MAX : U16_MAX;
         end
         // The reserved code 2'b11 is treated as a 32-bit target.
         default: begin
            w_min = i_out_signed ? S32_MIN : '0;
            w_max = i_out_signed ? S32_MAX : U32_MAX;
         end
      endcase
   end

   always_comb begin
      w_clamped = i_val;
      o_sat     = 1'b0;
      if (i_val < w_min) begin
         w_clamped = w_min;
         o_sat     = 1'b1;
      end else if (i_val > w_max) begin
         w_clamped = w_max;
         o_sat     = 1'b1;
      end
   end

   // An in-range signed value already carries its sign in bit 31 up; unsigned ranges have zeros there.
   assign o_data = w_clamped[31:0];

endmodule

// File: rtl/conv_sat_narrow_stage.sv
// Two-stage saturating narrowing pipeline with a global-stall valid/ready handshake and
// a sticky count of clamped beats accepted downstream.
module conv_sat_narrow_stage
   import conv_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_signed,
   input  logic [1:0]       in_width,
   input  logic             in_out_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_sat,
   output logic [CNT_W-1:0] sat_count,
   input  logic             sat_clr
);

   // Handshake: a beat moves across a port on a rising edge where valid && ready are both high.
   // Both stages advance together whenever the output register is empty or being drained.
   logic               w_advance;
   logic               r_s1_valid;
   logic signed [32:0] r_s1_val;
   logic [1:0]         r_s1_width;
   logic               r_s1_out_signed;
   logic [31:0]        w_clamp_data;
   logic               w_clamp_sat;

   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid      <= 1'b0;
         r_s1_val        <= '0;
         r_s1_width      <= '0;
         r_s1_out_signed <= 1'b0;
      end else if (w_advance) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_val        <= in_signed ? {in_data[31], in_data} : {1'b0, in_data};
            r_s1_width      <= in_width;
            r_s1_out_signed <= in_out_signed;
         end
      end
   end

   conv_sat_clamp u_clamp (
      .i_val        (r_s1_val),
      .i_width      (r_s1_width),
      .i_out_signed (r_s1_out_signed),
      .o_data       (w_clamp_data),
      .o_sat        (w_clamp_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (w_advance) begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            out_data <= w_clamp_data;
            out_sat  <= w_clamp_sat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_count <= '0;
      end else if (sat_clr) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && out_sat && (sat_count != {CNT_W{1'b1}})) begin
         sat_count <= sat_count + 1'b1;
      end
   end

endmodule
